sd_cmd_framer: RTL

SD_CMD_FRAMER -- requirements
Module: sd_cmd_framer

---
 rtl/sd_spi_pkg.sv | 34 +++
 rtl/sd_crc7_serial.sv | 34 +++
 rtl/sd_cmd_framer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared constants, the framer state type and the CRC7 step
// function for the SD-over-SPI command path.
//   SD_CRC7_POLY   : CRC7 generator x^7+x^3+1 with the x^7 term dropped
//   SD_FRAME_BYTES : bytes in one SD command frame
//   SD_HDR_BITS    : header bits covered by the CRC (start, tx, index, arg)
//   START_BIT/TX_BIT/END_BIT : fixed framing bits
package sd_spi_pkg;

  localparam logic [6:0] SD_CRC7_POLY   = 7'h09;
  localparam int         SD_FRAME_BYTES = 6;
  localparam int         SD_HDR_BITS    = 40;

  localparam logic START_BIT = 1'b0;
  localparam logic TX_BIT    = 1'b1;
  localparam logic END_BIT   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CRC,
    ST_SEND,
    ST_DONE
  } state_t;

  // One serial CRC7 step: shift left, fold in the polynomial when the
  // incoming bit differs from the bit leaving the register.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc,
                                           input logic       bit_in,
                                           input logic [6:0] poly);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? poly : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// sd_crc7_serial: one-bit-per-cycle CRC7 LFSR.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   clear      : synchronous clear of the register to zero
//   enable     : consume bit_in on this edge
//   bit_in     : next message bit, MSB of the message first
//   crc        : current CRC register contents
module sd_crc7_serial
  import sd_spi_pkg::*;
#(
  parameter logic [6:0] CRC_POLY = SD_CRC7_POLY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q;

  // NOTE: sequential state is written with non-blocking assignments only,
  // so every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      crc_q <= 7'h00;
    end else if (enable) begin
      crc_q <= crc7_step(crc_q, bit_in, CRC_POLY);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_framer.sv
// sd_cmd_framer: builds a 6-byte SD command frame (start/tx bits, index,
// argument, CRC7, end bit) and hands it byte by byte to an SPI shifter.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake; cmd_ready only in IDLE
//   cmd_index, cmd_arg  : command fields, latched on acceptance
//   byte_valid/ready    : byte handshake towards the shifter
//   byte_data           : current frame byte (0 outside SEND)
//   busy                : not IDLE
//   done                : one-cycle pulse after the last byte handshake
//   crc_out             : CRC7 of the last frame
// Build option: define SD_FRAMER_CRC_EN to compute the real CRC7 serially
// (40 extra cycles per frame). Without it the CRC field is all ones, so the
// last byte is 8'hFF, and the first byte follows acceptance directly.
module sd_cmd_framer
  import sd_spi_pkg::*;
#(
  parameter logic [6:0] CRC_POLY    = SD_CRC7_POLY,
  parameter int         FRAME_BYTES = SD_FRAME_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  byte_data,
  output logic        busy,
  output logic        done,
  output logic [6:0]  crc_out
);

  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

  state_t      state_q, state_d;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic [2:0]  byte_cnt_q;
  logic [6:0]  crc_out_q;
  logic        accept;
  logic        byte_hs;

  // cmd_ready is masked by reset so nothing is accepted on a reset edge.
  assign cmd_ready  = (state_q == ST_IDLE) && !reset;
  assign accept     = cmd_valid && cmd_ready;
  assign byte_valid = (state_q == ST_SEND);
  assign byte_hs    = byte_valid && byte_ready;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign crc_out    = crc_out_q;

`ifdef SD_FRAMER_CRC_EN
  localparam logic [5:0] LAST_BIT = 6'(SD_HDR_BITS - 1);

  logic [SD_HDR_BITS-1:0] header;
  logic [5:0]             bit_cnt_q;
  logic                   hdr_bit;
  logic [6:0]             lfsr;

  assign header  = {START_BIT, TX_BIT, idx_q, arg_q};
  assign hdr_bit = header[LAST_BIT - bit_cnt_q];

  sd_crc7_serial #(
    .CRC_POLY (CRC_POLY)
  ) u_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (state_q == ST_CRC),
    .bit_in (hdr_bit),
    .crc    (lfsr)
  );

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      bit_cnt_q <= '0;
    end else if (state_q == ST_CRC) begin
      bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end
`else
  // All-ones CRC field whatever the polynomial, since no CRC is computed.
  localparam logic [6:0] CRC_FILL = 7'h7F | CRC_POLY;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      arg_q      <= '0;
      byte_cnt_q <= '0;
      crc_out_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q      <= cmd_index;
        arg_q      <= cmd_arg;
        byte_cnt_q <= '0;
`ifndef SD_FRAMER_CRC_EN
        crc_out_q  <= CRC_FILL;
`endif
      end
      if (byte_hs && (byte_cnt_q != LAST_BYTE)) begin
        byte_cnt_q <= byte_cnt_q + 1'b1;
      end
`ifdef SD_FRAMER_CRC_EN
      // Capture the result of the 40th step on the same edge that leaves CRC.
      if ((state_q == ST_CRC) && (bit_cnt_q == LAST_BIT)) begin
        crc_out_q <= crc7_step(lfsr, hdr_bit, CRC_POLY);
      end
`endif
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef SD_FRAMER_CRC_EN
          state_d = ST_CRC;
`else
          state_d = ST_SEND;
`endif
        end
      end
`ifdef SD_FRAMER_CRC_EN
      ST_CRC:  if (bit_cnt_q == LAST_BIT) state_d = ST_SEND;
`else
      ST_CRC:  state_d = ST_IDLE;
`endif
      ST_SEND: if (byte_hs && (byte_cnt_q == LAST_BYTE)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_data = 8'h00;
    if (state_q == ST_SEND) begin
      case (byte_cnt_q)
        3'd0:    byte_data = {START_BIT, TX_BIT, idx_q};
        3'd1:    byte_data = arg_q[31:24];
        3'd2:    byte_data = arg_q[23:16];
        3'd3:    byte_data = arg_q[15:8];
        3'd4:    byte_data = arg_q[7:0];
        default: byte_data = {crc_out_q, END_BIT};
      endcase
    end
  end

endmodule
